// File: rtl/iir_ctrl_pkg.sv
// Shared types and constants for the IIR filter stage controller:
// FSM encoding, coefficient select codes and power-up coefficient defaults.
package iir_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISABLE,
    ST_LOAD,
    ST_CLEAR,
    ST_SETTLE,
    ST_RUN
  } state_t;

  localparam logic [1:0] CFG_SEL_B1 = 2'd0;
  localparam logic [1:0] CFG_SEL_B2 = 2'd1;
  localparam logic [1:0] CFG_SEL_A2 = 2'd2;

  // Default first-order low-pass; A1 is implicitly 2^A1_LOG2 inside the filter
  localparam int DEF_B1 = 128;
  localparam int DEF_B2 = 128;
  localparam int DEF_A2 = -65279;

  localparam int unsigned A1_LOG2 = 16;

endpackage

// File: rtl/iir_coef_bank.sv
// N_SETS x {B1, B2, A2} coefficient register file: one write port, one
// asynchronous read port. Bank 0 resets to the defaults, other banks to zero.
module iir_coef_bank
  import iir_ctrl_pkg::*;
#(
  parameter int unsigned N_SETS = 4,
  parameter int unsigned COEF_W = 32,
  localparam int unsigned SET_W = $clog2(N_SETS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [SET_W-1:0]  wr_set,
  input  logic [1:0]        wr_sel,
  input  logic [COEF_W-1:0] wr_data,
  input  logic [SET_W-1:0]  rd_set,
  output logic [COEF_W-1:0] rd_b1_c,
  output logic [COEF_W-1:0] rd_b2_c,
  output logic [COEF_W-1:0] rd_a2_c
);

  logic [COEF_W-1:0] b1_mem [N_SETS];
  logic [COEF_W-1:0] b2_mem [N_SETS];
  logic [COEF_W-1:0] a2_mem [N_SETS];

  logic wr_ok;
  assign wr_ok = we && (32'(wr_set) < N_SETS);

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < int'(N_SETS); i++) begin
        b1_mem[i] <= (i == 0) ? COEF_W'(DEF_B1) : '0;
        b2_mem[i] <= (i == 0) ? COEF_W'(DEF_B2) : '0;
        a2_mem[i] <= (i == 0) ? COEF_W'(DEF_A2) : '0;
      end
    end else if (wr_ok) begin
      // Reserved select code is dropped silently
      case (wr_sel)
        CFG_SEL_B1: b1_mem[wr_set] <= wr_data;
        CFG_SEL_B2: b2_mem[wr_set] <= wr_data;
        CFG_SEL_A2: a2_mem[wr_set] <= wr_data;
        default: ;
      endcase
    end
  end

  assign rd_b1_c = b1_mem[rd_set];
  assign rd_b2_c = b2_mem[rd_set];
  assign rd_a2_c = a2_mem[rd_set];

endmodule

// File: rtl/iir_filter_ctrl.sv
// Bank-switch sequencer for one first-order IIR stage:
// disable -> hold coefs -> clear filter state -> discard settling samples -> run.
module iir_filter_ctrl
  import iir_ctrl_pkg::*;
#(
  parameter int unsigned N_SETS         = 4,
  parameter int unsigned COEF_W         = 32,
  parameter int unsigned HOLD_CYCLES    = 2,
  parameter int unsigned CLR_CYCLES     = 1,
  parameter int unsigned SETTLE_SAMPLES = 16,
  localparam int unsigned SET_W = $clog2(N_SETS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [SET_W-1:0]  cfg_set,
  input  logic [1:0]        cfg_sel,
  input  logic [COEF_W-1:0] cfg_data,
  input  logic              sel_req,
  input  logic [SET_W-1:0]  sel_set,
  input  logic              filt_out_valid,
  output logic              filt_enable,
  output logic              filt_reset_n,
  output logic [COEF_W-1:0] filt_B1,
  output logic [COEF_W-1:0] filt_B2,
  output logic [COEF_W-1:0] filt_A2,
  output logic              out_valid_gated,
  output logic [SET_W-1:0]  active_set,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned PH_MAX = (HOLD_CYCLES > CLR_CYCLES) ? HOLD_CYCLES : CLR_CYCLES;
  localparam int unsigned PCNT_W = $clog2(PH_MAX + 1);
  localparam int unsigned SCNT_W = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;

  state_t             state, state_nxt;
  logic [PCNT_W-1:0]  phase_cnt;
  logic [SCNT_W-1:0]  settle_cnt;
  logic               accept, reject;
  logic               enable_nxt, reset_n_nxt, busy_nxt, done_nxt;
  logic [COEF_W-1:0]  bank_b1, bank_b2, bank_a2;

  iir_coef_bank #(
    .N_SETS (N_SETS),
    .COEF_W (COEF_W)
  ) u_bank (
    .clock   (clock),
    .reset   (reset),
    .we      (cfg_we),
    .wr_set  (cfg_set),
    .wr_sel  (cfg_sel),
    .wr_data (cfg_data),
    .rd_set  (sel_set),
    .rd_b1_c (bank_b1),
    .rd_b2_c (bank_b2),
    .rd_a2_c (bank_a2)
  );

  // Next state and next registered outputs
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    reject      = 1'b0;
    if (sel_req) begin
      if ((state == ST_IDLE || state == ST_RUN) && (32'(sel_set) < N_SETS)) accept = 1'b1;
      else reject = 1'b1;
    end
    case (state)
      ST_IDLE, ST_RUN: if (accept) state_nxt = ST_DISABLE;
      ST_DISABLE:      state_nxt = ST_LOAD;
      ST_LOAD:   if (phase_cnt == PCNT_W'(HOLD_CYCLES - 1)) state_nxt = ST_CLEAR;
      ST_CLEAR:  if (phase_cnt == PCNT_W'(CLR_CYCLES - 1))
                   state_nxt = (SETTLE_SAMPLES == 0) ? ST_RUN : ST_SETTLE;
      ST_SETTLE: if (filt_out_valid && settle_cnt == SCNT_W'(SETTLE_SAMPLES - 1))
                   state_nxt = ST_RUN;
      default:   state_nxt = ST_IDLE;
    endcase
    enable_nxt  = (state_nxt == ST_SETTLE) || (state_nxt == ST_RUN);
    reset_n_nxt = (state_nxt != ST_IDLE) && (state_nxt != ST_CLEAR);
    busy_nxt    = (state_nxt != ST_IDLE) && (state_nxt != ST_RUN);
    done_nxt    = (state_nxt == ST_RUN) && (state != ST_RUN);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= ST_IDLE;
      phase_cnt    <= '0;
      settle_cnt   <= '0;
      filt_enable  <= 1'b0;
      filt_reset_n <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      active_set   <= '0;
      filt_B1      <= COEF_W'(DEF_B1);
      filt_B2      <= COEF_W'(DEF_B2);
      filt_A2      <= COEF_W'(DEF_A2);
    end else begin
      state        <= state_nxt;
      filt_enable  <= enable_nxt;
      filt_reset_n <= reset_n_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      err          <= reject;
      if (state_nxt != state) phase_cnt <= '0;
      else if (state == ST_LOAD || state == ST_CLEAR) phase_cnt <= phase_cnt + 1'b1;
      // Counts valid samples only while settling; saturates at the target
      if (state != ST_SETTLE) settle_cnt <= '0;
      else if (filt_out_valid && settle_cnt < SCNT_W'(SETTLE_SAMPLES))
        settle_cnt <= settle_cnt + 1'b1;
      // Snapshot is the pre-write bank value when a write lands on the same edge
      if (accept) begin
        active_set <= sel_set;
        filt_B1    <= bank_b1;
        filt_B2    <= bank_b2;
        filt_A2    <= bank_a2;
      end
    end
  end

  assign out_valid_gated = filt_out_valid && (state == ST_RUN);

endmodule

// File: tb/tb_iir_filter_ctrl.sv
// Directed bench for iir_filter_ctrl: u_dut0 is the default build, u_dut1 the
// SETTLE_SAMPLES=0 build; both share stimulus.
module tb_iir_filter_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_set = '0;
  logic [1:0]  cfg_sel = '0;
  logic [31:0] cfg_data = '0;
  logic        sel_req = 1'b0;
  logic [1:0]  sel_set = '0;
  logic        filt_out_valid = 1'b0;

  logic        en0, rn0, ovg0, busy0, done0, err0;
  logic [31:0] b1_0, b2_0, a2_0;
  logic [1:0]  as0;
  logic        en1, rn1, ovg1, busy1, done1, err1;
  logic [31:0] b1_1, b2_1, a2_1;
  logic [1:0]  as1;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  iir_filter_ctrl u_dut0 (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_set(cfg_set), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .sel_req(sel_req), .sel_set(sel_set), .filt_out_valid(filt_out_valid),
    .filt_enable(en0), .filt_reset_n(rn0), .filt_B1(b1_0), .filt_B2(b2_0), .filt_A2(a2_0),
    .out_valid_gated(ovg0), .active_set(as0), .busy(busy0), .done(done0), .err(err0)
  );

  iir_filter_ctrl #(.SETTLE_SAMPLES(0)) u_dut1 (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_set(cfg_set), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .sel_req(sel_req), .sel_set(sel_set), .filt_out_valid(filt_out_valid),
    .filt_enable(en1), .filt_reset_n(rn1), .filt_B1(b1_1), .filt_B2(b2_1), .filt_A2(a2_1),
    .out_valid_gated(ovg1), .active_set(as1), .busy(busy1), .done(done1), .err(err1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] set, input logic [1:0] sel, input logic [31:0] data);
    cfg_we = 1'b1; cfg_set = set; cfg_sel = sel; cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  // Issue a one-cycle request; returns in the DISABLE cycle
  task automatic request(input logic [1:0] set);
    sel_req = 1'b1; sel_set = set;
    tick();
    sel_req = 1'b0;
  endtask

  // 16 valid pulses on alternate cycles; returns just after the 16th edge
  task automatic settle_16(input string tag);
    for (int i = 0; i < 16; i++) begin
      filt_out_valid = 1'b1;
      tick();
      filt_out_valid = 1'b0;
      if (i == 14) check({tag, "_not_early"}, 32'(done0), 0);
      if (i < 15) tick();
    end
  endtask

  initial begin
    // 1: reset state, then default-bank sequence
    tick(); tick();
    filt_out_valid = 1'b1;
    #1;
    check("rst_enable", 32'(en0), 0);
    check("rst_reset_n", 32'(rn0), 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_done", 32'(done0), 0);
    check("rst_err", 32'(err0), 0);
    check("rst_gated", 32'(ovg0), 0);
    check("rst_active", 32'(as0), 0);
    check("rst_b1", b1_0, 128);
    check("rst_b2", b2_0, 128);
    check("rst_a2", a2_0, -65279);
    filt_out_valid = 1'b0;
    reset = 1'b1;
    tick();
    check("idle_reset_n", 32'(rn0), 0);

    request(2'd0);
    check("t1_dis_busy", 32'(busy0), 1);
    check("t1_dis_enable", 32'(en0), 0);
    check("t1_dis_reset_n", 32'(rn0), 1);
    tick();
    check("t1_load1_enable", 32'(en0), 0);
    tick();
    check("t1_load2_reset_n", 32'(rn0), 1);
    tick();
    check("t1_clear_reset_n", 32'(rn0), 0);
    check("t1_clear_enable", 32'(en0), 0);
    tick();
    check("t1_settle_reset_n", 32'(rn0), 1);
    check("t1_settle_enable", 32'(en0), 1);
    check("t1_settle_busy", 32'(busy0), 1);
    // 6: zero-settle build reaches RUN at t+5
    check("t6_run_done", 32'(done1), 1);
    check("t6_run_busy", 32'(busy1), 0);
    check("t6_run_enable", 32'(en1), 1);
    filt_out_valid = 1'b1;
    #1;
    check("t6_gated_hi", 32'(ovg1), 1);
    check("t1_settle_gated", 32'(ovg0), 0);
    filt_out_valid = 1'b0;
    #1;
    check("t6_gated_lo", 32'(ovg1), 0);

    settle_16("t1");
    check("t1_done", 32'(done0), 1);
    check("t1_run_busy", 32'(busy0), 0);
    check("t1_run_enable", 32'(en0), 1);
    check("t1_b1", b1_0, 128);
    check("t1_a2", a2_0, -65279);
    tick();
    check("t1_done_pulse", 32'(done0), 0);
    filt_out_valid = 1'b1;
    #1;
    check("t1_run_gated", 32'(ovg0), 1);
    filt_out_valid = 1'b0;

    // 2: program bank 2 and switch to it from RUN
    cfg_write(2'd2, 2'd0, 32'd256);
    cfg_write(2'd2, 2'd1, 32'd256);
    cfg_write(2'd2, 2'd2, -32'sd65024);
    request(2'd2);
    check("t2_dis_b1", b1_0, 256);
    check("t2_dis_b2", b2_0, 256);
    check("t2_dis_a2", a2_0, -65024);
    check("t2_active", 32'(as0), 2);
    check("t2_dis_enable", 32'(en0), 0);
    tick();
    check("t2_load1_enable", 32'(en0), 0);
    tick();
    check("t2_load2_enable", 32'(en0), 0);
    tick();
    check("t2_clear_enable", 32'(en0), 0);
    tick();
    check("t2_settle_enable", 32'(en0), 1);
    check("t2_d1_done", 32'(done1), 1);
    settle_16("t2");
    check("t2_done", 32'(done0), 1);

    // 3: request while settling is rejected
    tick();
    request(2'd1);
    tick(); tick(); tick(); tick();
    check("t3_in_settle", 32'(en0), 1);
    check("t3_busy_pre", 32'(busy0), 1);
    request(2'd3);
    check("t3_err", 32'(err0), 1);
    check("t3_active", 32'(as0), 1);
    check("t3_busy", 32'(busy0), 1);
    check("t3_d1_accept_err", 32'(err1), 0);
    check("t3_d1_accept_busy", 32'(busy1), 1);
    tick();
    check("t3_err_pulse", 32'(err0), 0);
    settle_16("t3");
    check("t3_done", 32'(done0), 1);
    check("t3_active_end", 32'(as0), 1);
    tick();
    check("t3_done_once", 32'(done0), 0);
    check("t3_idle_busy", 32'(busy0), 0);
    tick();
    check("t3_no_rerun", 32'(done0), 0);

    // 4: writes to the active bank need a new request to apply
    cfg_write(2'd1, 2'd0, 32'd999);
    cfg_write(2'd1, 2'd3, 32'd5);
    cfg_write(2'd0, 2'd0, 32'd777);
    tick();
    check("t4_b1_held", b1_0, 0);
    cfg_we = 1'b1; cfg_set = 2'd1; cfg_sel = 2'd0; cfg_data = 32'd111;
    request(2'd1);
    cfg_we = 1'b0;
    check("t4_b1_applied", b1_0, 999);
    check("t4_b2_reserved", b2_0, 0);
    check("t4_a2_reserved", a2_0, 0);

    // 5: reset in LOAD aborts and restores defaults
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("t5_enable", 32'(en0), 0);
    check("t5_reset_n", 32'(rn0), 0);
    check("t5_busy", 32'(busy0), 0);
    check("t5_err", 32'(err0), 0);
    check("t5_active", 32'(as0), 0);
    check("t5_b1", b1_0, 128);
    check("t5_a2", a2_0, -65279);
    tick();
    check("t5_idle_hold", 32'(busy0), 0);
    request(2'd0);
    check("t5_bank0_b1", b1_0, 128);
    check("t5_bank0_b2", b2_0, 128);
    request(2'd1);
    check("t5_reject_in_disable", 32'(err0), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
